// File: rtl/hps_frame_read_sequencer_pkg.sv
// Shared constants and state encoding for the HPS frame read sequencer.
// Frame geometry defaults match a 640x480 frame packed 8 pixels per byte.
package hps_seq_pkg;

    localparam int COLS_BYTES_DEF = 80;
    localparam int ROWS_DEF       = 480;
    localparam int COL_W          = $clog2(COLS_BYTES_DEF);
    localparam int ROW_W          = $clog2(ROWS_DEF);
    localparam int CNT_W          = 32;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_WAIT_SOF   = 4'd1,
        S_CAPTURE    = 4'd2,
        S_DRAIN      = 4'd3,
        S_SERVE_IDLE = 4'd4,
        S_SERVE_WAIT = 4'd5,
        S_SERVE_ACK  = 4'd6,
        S_DONE       = 4'd7,
        S_ERROR      = 4'd8
    } seq_state_t;

endpackage

// File: rtl/hps_frame_read_sequencer_sync.sv
// Two-flop synchroniser for a single asynchronous level.
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/hps_frame_read_sequencer.sv
// Captures one camera frame into SDRAM on HPS request, then serves it byte by byte
// to the HPS through a four-phase req/ack handshake.
module hps_frame_read_sequencer
    import hps_seq_pkg::*;
#(
    parameter int COLS_BYTES  = COLS_BYTES_DEF,
    parameter int ROWS        = ROWS_DEF,
    parameter int RD_LAT      = 2,
    parameter int DRAIN_CYC   = 4096,
    parameter int TIMEOUT_CYC = 50000000
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iSTART,
    input  logic             iFVAL,
    input  logic             iHPS_REQ,
    input  logic [7:0]       iFIFO_DATA,
    output logic             oFIFO_RD,
    output logic             oFIFO_LOAD,
    output logic             oCAPTURE,
    output logic [7:0]       oDATA,
    output logic             oHPS_ACK,
    output logic [ROW_W-1:0] oROW,
    output logic [COL_W-1:0] oCOL,
    output logic             oDONE,
    output logic             oERR,
    output logic [3:0]       oSTATE
);

    logic start_s, fval_s, req_s;
    logic start_d, fval_d;
    logic start_rise, start_fall, fval_fall;

    bit_sync u_sync_start (.clk(iCLK), .rst(iRST), .d(iSTART),   .q(start_s));
    bit_sync u_sync_fval  (.clk(iCLK), .rst(iRST), .d(iFVAL),    .q(fval_s));
    bit_sync u_sync_req   (.clk(iCLK), .rst(iRST), .d(iHPS_REQ), .q(req_s));

    assign start_rise = start_s & ~start_d;
    assign start_fall = ~start_s & start_d;
    assign fval_fall  = ~fval_s & fval_d;

    seq_state_t       state, nxt;
    logic [CNT_W-1:0] cyc_cnt;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [7:0]       data_q;
    logic             tmo_hit, drain_hit, lat_hit, col_end, last_byte;

    // One cycle counter serves timeout, drain and read latency; it restarts on every state change.
    assign tmo_hit   = (cyc_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign drain_hit = (cyc_cnt == CNT_W'(DRAIN_CYC - 1));
    assign lat_hit   = (cyc_cnt == CNT_W'(RD_LAT - 1));
    assign col_end   = (col == COL_W'(COLS_BYTES - 1));
    assign last_byte = col_end && (row == ROW_W'(ROWS - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= S_IDLE;
        else      state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (state != S_IDLE && start_fall) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:       if (start_rise) nxt = S_WAIT_SOF;
                S_WAIT_SOF:   if (fval_fall) nxt = S_CAPTURE;
                              else if (tmo_hit) nxt = S_ERROR;
                S_CAPTURE:    if (fval_fall) nxt = S_DRAIN;
                              else if (tmo_hit) nxt = S_ERROR;
                S_DRAIN:      if (drain_hit) nxt = S_SERVE_IDLE;
                S_SERVE_IDLE: if (req_s) nxt = S_SERVE_WAIT;
                S_SERVE_WAIT: if (lat_hit) nxt = S_SERVE_ACK;
                S_SERVE_ACK:  if (!req_s) nxt = last_byte ? S_DONE : S_SERVE_IDLE;
                S_DONE:       ;
                S_ERROR:      ;
                default:      nxt = S_IDLE;
            endcase
        end
    end

    // Strobes look at nxt so an abort in the same cycle suppresses them.
    always_comb begin
        oFIFO_LOAD = 1'b0;
        oFIFO_RD   = 1'b0;
        oCAPTURE   = 1'b0;
        oHPS_ACK   = 1'b0;
        oDONE      = 1'b0;
        oERR       = 1'b0;
        case (state)
            S_IDLE:       oFIFO_LOAD = start_rise;
            S_DRAIN:      oFIFO_LOAD = (nxt == S_SERVE_IDLE);
            S_CAPTURE:    oCAPTURE   = 1'b1;
            S_SERVE_IDLE: oFIFO_RD   = (nxt == S_SERVE_WAIT);
            S_SERVE_ACK:  oHPS_ACK   = 1'b1;
            S_DONE:       oDONE      = 1'b1;
            S_ERROR:      oERR       = 1'b1;
            default:      ;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            start_d <= 1'b0;
            fval_d  <= 1'b0;
            cyc_cnt <= '0;
            row     <= '0;
            col     <= '0;
            data_q  <= '0;
        end else begin
            start_d <= start_s;
            fval_d  <= fval_s;
            cyc_cnt <= (nxt != state) ? '0 : cyc_cnt + 1'b1;
            if (state == S_SERVE_WAIT && nxt == S_SERVE_ACK)
                data_q <= iFIFO_DATA;
            // Position holds on the last byte so DONE still reports it.
            if (state != S_IDLE && nxt == S_IDLE) begin
                row <= '0;
                col <= '0;
            end else if (state == S_SERVE_ACK && nxt == S_SERVE_IDLE) begin
                if (col_end) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    assign oDATA  = data_q;
    assign oROW   = row;
    assign oCOL   = col;
    assign oSTATE = state;

endmodule

// File: tb/tb_hps_frame_read_sequencer.sv
// Self-checking bench for hps_frame_read_sequencer on a reduced 4x3-byte frame.
module tb_hps_frame_read_sequencer;

    localparam int COLS = 4;
    localparam int ROWS = 3;
    localparam int NB   = COLS * ROWS;
    localparam int RDL  = 2;
    localparam int DRN  = 16;
    localparam int TMO  = 1000;

    logic       clk = 1'b0;
    logic       iRST, iSTART, iFVAL, iHPS_REQ;
    logic [7:0] iFIFO_DATA;
    logic       oFIFO_RD, oFIFO_LOAD, oCAPTURE, oHPS_ACK, oDONE, oERR;
    logic [7:0] oDATA;
    logic [8:0] oROW;
    logic [6:0] oCOL;
    logic [3:0] oSTATE;

    hps_frame_read_sequencer #(
        .COLS_BYTES(COLS), .ROWS(ROWS), .RD_LAT(RDL), .DRAIN_CYC(DRN), .TIMEOUT_CYC(TMO)
    ) dut (
        .iCLK(clk), .iRST(iRST), .iSTART(iSTART), .iFVAL(iFVAL), .iHPS_REQ(iHPS_REQ),
        .iFIFO_DATA(iFIFO_DATA), .oFIFO_RD(oFIFO_RD), .oFIFO_LOAD(oFIFO_LOAD),
        .oCAPTURE(oCAPTURE), .oDATA(oDATA), .oHPS_ACK(oHPS_ACK), .oROW(oROW), .oCOL(oCOL),
        .oDONE(oDONE), .oERR(oERR), .oSTATE(oSTATE)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic [8:0] r;
        logic [6:0] c;
    } exp_t;
    exp_t exp_q[$];

    // SDRAM FIFO model: reload on load, data valid only RD_LAT cycles after the strobe cycle.
    int         fifo_ptr = 0;
    int         ptr_d1   = 0;
    logic       rd_d1    = 1'b0;
    int         rd_cnt   = 0;
    int         load_cnt = 0;
    int         viol     = 0;
    logic       ack_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;

    always @(posedge clk) begin
        iFIFO_DATA <= rd_d1 ? 8'(ptr_d1) : 8'hEE;
        rd_d1      <= oFIFO_RD;
        ptr_d1     <= fifo_ptr;
        if (oFIFO_LOAD)    fifo_ptr <= 0;
        else if (oFIFO_RD) fifo_ptr <= fifo_ptr + 1;
        if (oFIFO_RD)   rd_cnt   <= rd_cnt + 1;
        if (oFIFO_LOAD) load_cnt <= load_cnt + 1;
        if (oFIFO_RD && oHPS_ACK) viol <= viol + 1;
    end

    always @(negedge clk) begin
        if (oHPS_ACK && ack_prev && oDATA !== data_prev) viol <= viol + 1;
        ack_prev  <= oHPS_ACK;
        data_prev <= oDATA;
    end

    logic [7:0] got_d;
    logic [8:0] got_r;
    logic [6:0] got_c;

    task automatic wait_state(input logic [3:0] s, input int bound);
        int n = 0;
        while (oSTATE !== s && n < bound) begin
            @(negedge clk);
            n++;
        end
    endtask

    // Drives a capture sequence; ok reports whether SERVE_IDLE was reached in time.
    task automatic goto_serve(output bit ok);
        iSTART = 1'b1;
        repeat (2) begin
            iFVAL = 1'b1; repeat (8) @(negedge clk);
            iFVAL = 1'b0; repeat (4) @(negedge clk);
        end
        wait_state(4'd4, 200);
        ok = (oSTATE === 4'd4);
    endtask

    // One HPS-side handshake; lat is negedges from req rise to ack seen.
    task automatic hps_xfer(output int lat, output bit ok);
        int n = 0;
        iHPS_REQ = 1'b1;
        while (oHPS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        lat = n;
        ok  = (oHPS_ACK === 1'b1);
        got_d = oDATA; got_r = oROW; got_c = oCOL;
        iHPS_REQ = 1'b0;
        n = 0;
        while (oHPS_ACK !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        ok = ok && (oHPS_ACK === 1'b0);
    endtask

    task automatic test_reset;
        checks++;
        if ({oFIFO_RD, oFIFO_LOAD, oCAPTURE, oHPS_ACK, oDONE, oERR} !== 6'b0 || oDATA !== 8'h00 ||
            oROW !== 9'd0 || oCOL !== 7'd0 || oSTATE !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b ld=%b cap=%b ack=%b done=%b err=%b data=%h row=%0d col=%0d st=%0d, want all 0",
                     oFIFO_RD, oFIFO_LOAD, oCAPTURE, oHPS_ACK, oDONE, oERR, oDATA, oROW, oCOL, oSTATE);
        end
    endtask

    task automatic test_capture;
        int ld0 = load_cnt;
        int dcyc = 0;
        logic last_ld = 1'b0;
        iSTART = 1'b1;
        wait_state(4'd1, 20);
        checks++;
        if (oSTATE !== 4'd1 || load_cnt - ld0 !== 1) begin
            errors++;
            $display("FAIL start_load: state=%0d loads=%0d, want state=1 loads=1", oSTATE, load_cnt - ld0);
        end
        iFVAL = 1'b1; repeat (40) @(negedge clk);
        checks++;
        if (oCAPTURE !== 1'b0 || oSTATE !== 4'd1) begin
            errors++;
            $display("FAIL capture_before_sof: cap=%b state=%0d, want cap=0 state=1", oCAPTURE, oSTATE);
        end
        iFVAL = 1'b0; repeat (4) @(negedge clk);
        iFVAL = 1'b1; repeat (40) @(negedge clk);
        checks++;
        if (oCAPTURE !== 1'b1 || oSTATE !== 4'd2) begin
            errors++;
            $display("FAIL capture_in_frame: cap=%b state=%0d, want cap=1 state=2", oCAPTURE, oSTATE);
        end
        iFVAL = 1'b0;
        wait_state(4'd3, 10);
        checks++;
        if (oCAPTURE !== 1'b0 || oSTATE !== 4'd3) begin
            errors++;
            $display("FAIL capture_end: cap=%b state=%0d, want cap=0 state=3", oCAPTURE, oSTATE);
        end
        while (oSTATE === 4'd3 && dcyc < 100) begin
            dcyc++;
            last_ld = oFIFO_LOAD;
            @(negedge clk);
        end
        checks++;
        if (dcyc !== DRN || last_ld !== 1'b1 || oSTATE !== 4'd4 || load_cnt - ld0 !== 2) begin
            errors++;
            $display("FAIL drain: cycles=%0d last_load=%b state=%0d loads=%0d, want %0d 1 4 2",
                     dcyc, last_ld, oSTATE, load_cnt - ld0, DRN);
        end
    endtask

    task automatic test_frame;
        int lat; bit ok; exp_t e;
        int rd0 = rd_cnt;
        for (int i = 0; i < NB; i++) begin
            exp_q.push_back('{d: 8'(i), r: 9'(i / COLS), c: 7'(i % COLS)});
            hps_xfer(lat, ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || got_d !== e.d || got_r !== e.r || got_c !== e.c) begin
                errors++;
                $display("FAIL frame_byte%0d: ok=%0b data=%h row=%0d col=%0d, want data=%h row=%0d col=%0d",
                         i, ok, got_d, got_r, got_c, e.d, e.r, e.c);
            end
        end
        checks++;
        if (oDONE !== 1'b1 || oSTATE !== 4'd7 || oROW !== 9'(ROWS-1) || oCOL !== 7'(COLS-1) ||
            rd_cnt - rd0 !== NB || viol !== 0) begin
            errors++;
            $display("FAIL frame_done: done=%b state=%0d row=%0d col=%0d reads=%0d viol=%0d, want 1 7 %0d %0d %0d 0",
                     oDONE, oSTATE, oROW, oCOL, rd_cnt - rd0, viol, ROWS-1, COLS-1, NB);
        end
        iSTART = 1'b0;
        wait_state(4'd0, 10);
        checks++;
        if (oSTATE !== 4'd0 || oDONE !== 1'b0 || oROW !== 9'd0 || oCOL !== 7'd0) begin
            errors++;
            $display("FAIL done_exit: state=%0d done=%b row=%0d col=%0d, want 0 0 0 0", oSTATE, oDONE, oROW, oCOL);
        end
    endtask

    task automatic test_hold_req;
        int n; bit ok; exp_t e;
        int rd0;
        goto_serve(ok);
        rd0 = rd_cnt;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{d: 8'(k), r: 9'd0, c: 7'(k)});
            iHPS_REQ = 1'b1;
            n = 0;
            while (oHPS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
            e = exp_q.pop_front();
            checks++;
            if (!ok || n !== 3 + RDL || oDATA !== e.d || oCOL !== e.c) begin
                errors++;
                $display("FAIL ack_latency%0d: lat=%0d data=%h col=%0d, want lat=%0d data=%h col=%0d",
                         k, n, oDATA, oCOL, 3 + RDL, e.d, e.c);
            end
            repeat (20) @(negedge clk);
            checks++;
            if (oHPS_ACK !== 1'b1 || rd_cnt - rd0 !== k + 1) begin
                errors++;
                $display("FAIL held_req%0d: ack=%b reads=%0d, want ack=1 reads=%0d", k, oHPS_ACK, rd_cnt - rd0, k + 1);
            end
            iHPS_REQ = 1'b0;
            n = 0;
            while (oHPS_ACK !== 1'b0 && n < 50) begin @(negedge clk); n++; end
        end
        iSTART = 1'b0;
        wait_state(4'd0, 10);
    endtask

    task automatic test_timeout;
        int n = 0;
        iFVAL  = 1'b0;
        iSTART = 1'b1;
        wait_state(4'd1, 20);
        while (oSTATE === 4'd1 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (n !== TMO || oSTATE !== 4'd8 || oERR !== 1'b1 || oCAPTURE !== 1'b0) begin
            errors++;
            $display("FAIL timeout: cycles=%0d state=%0d err=%b cap=%b, want %0d 8 1 0", n, oSTATE, oERR, oCAPTURE, TMO);
        end
        iSTART = 1'b0;
        wait_state(4'd0, 10);
        checks++;
        if (oSTATE !== 4'd0 || oERR !== 1'b0) begin
            errors++;
            $display("FAIL error_exit: state=%0d err=%b, want 0 0", oSTATE, oERR);
        end
    endtask

    task automatic test_abort;
        int lat, n, rd0; bit ok, ok2; exp_t e;
        logic ack_before = 1'b0;
        goto_serve(ok);
        for (int i = 0; i < 5; i++) hps_xfer(lat, ok2);
        exp_q.push_back('{d: 8'd5, r: 9'd1, c: 7'd1});
        iHPS_REQ = 1'b1;
        n = 0;
        while (oHPS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        e = exp_q.pop_front();
        checks++;
        if (!ok || oDATA !== e.d || oROW !== e.r || oCOL !== e.c) begin
            errors++;
            $display("FAIL abort_byte: data=%h row=%0d col=%0d, want %h %0d %0d", oDATA, oROW, oCOL, e.d, e.r, e.c);
        end
        // Drop start and req together: the abort must win over the col advance.
        iSTART = 1'b0; iHPS_REQ = 1'b0;
        n = 0;
        while (oSTATE !== 4'd0 && n < 10) begin ack_before = oHPS_ACK; @(negedge clk); n++; end
        rd0 = rd_cnt;
        checks++;
        if (oSTATE !== 4'd0 || oHPS_ACK !== 1'b0 || ack_before !== 1'b1 || oROW !== 9'd0 || oCOL !== 7'd0) begin
            errors++;
            $display("FAIL abort: state=%0d ack=%b ack_before=%b row=%0d col=%0d, want 0 0 1 0 0",
                     oSTATE, oHPS_ACK, ack_before, oROW, oCOL);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (rd_cnt !== rd0 || oSTATE !== 4'd0) begin
            errors++;
            $display("FAIL abort_quiet: reads=%0d state=%0d, want reads=%0d state=0", rd_cnt, oSTATE, rd0);
        end
        goto_serve(ok);
        exp_q.push_back('{d: 8'd0, r: 9'd0, c: 7'd0});
        hps_xfer(lat, ok2);
        e = exp_q.pop_front();
        checks++;
        if (!ok || !ok2 || got_d !== e.d || got_r !== e.r || got_c !== e.c) begin
            errors++;
            $display("FAIL restart: data=%h row=%0d col=%0d, want %h %0d %0d", got_d, got_r, got_c, e.d, e.r, e.c);
        end
        iSTART = 1'b0;
        wait_state(4'd0, 10);
    endtask

    task automatic test_reset_mid_serve;
        int n = 0; int rd0; bit ok;
        goto_serve(ok);
        iHPS_REQ = 1'b1;
        while (oHPS_ACK !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        iRST = 1'b1;
        #1;
        checks++;
        if (!ok || {oFIFO_RD, oFIFO_LOAD, oCAPTURE, oHPS_ACK, oDONE, oERR} !== 6'b0 ||
            oDATA !== 8'h00 || oROW !== 9'd0 || oCOL !== 7'd0 || oSTATE !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid_serve: ack=%b data=%h row=%0d col=%0d st=%0d, want all 0",
                     oHPS_ACK, oDATA, oROW, oCOL, oSTATE);
        end
        rd0 = rd_cnt;
        repeat (5) @(negedge clk);
        iRST = 1'b0;
        repeat (30) @(negedge clk);
        checks++;
        if (rd_cnt !== rd0) begin
            errors++;
            $display("FAIL no_read_after_reset: reads=%0d, want %0d", rd_cnt, rd0);
        end
        iSTART = 1'b0; iHPS_REQ = 1'b0;
        wait_state(4'd0, 10);
    endtask

    initial begin
        iRST = 1'b1; iSTART = 1'b0; iFVAL = 1'b0; iHPS_REQ = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        iRST = 1'b0;
        repeat (3) @(negedge clk);
        test_capture();
        test_frame();
        test_hold_req();
        test_timeout();
        test_abort();
        test_reset_mid_serve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
